// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared FSM encoding and result width for the MAC scheduler
package mac_pkg;

    localparam int MAC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last served index
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_last,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_idx
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] w_k;
    logic          w_found;

    // Walk last+1 .. last+NREQ (mod NREQ); the first asserted request wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_k     = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            w_k = IW'((int'(i_last) + i) % NREQ);
            if (!w_found && i_req[w_k]) begin
                w_found    = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
    end

endmodule

// File: rtl/mac_sched.sv
// rtl/mac_sched.sv - round-robin scheduler sharing one MAC among NREQ requesters with timeout
module mac_sched
    import mac_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int PARALLEL = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*PARALLEL*8-1:0] req_din_a,
    input  logic [NREQ*PARALLEL*8-1:0] req_din_b,
    output logic [NREQ-1:0]            grant,
    output logic [PARALLEL*8-1:0]      mac_din_a,
    output logic [PARALLEL*8-1:0]      mac_din_b,
    output logic                       mac_start,
    input  logic                       mac_done,
    input  logic [MAC_W-1:0]           mac_dout,
    output logic                       rsp_valid,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [MAC_W-1:0]           rsp_data,
    output logic                       rsp_err
);

    localparam int W  = PARALLEL * 8;
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    logic [NREQ-1:0]  r_grant;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_last;
    logic [CW-1:0]    r_cnt;
    logic             r_mac_start;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [MAC_W-1:0] r_rsp_data;
    logic [IW-1:0]    r_rsp_id;

    logic [NREQ-1:0]  w_win_gnt;
    logic [IW-1:0]    w_win_idx;
    logic [W-1:0]     w_din_a;
    logic [W-1:0]     w_din_b;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req  (req),
        .i_last (r_last),
        .o_gnt  (w_win_gnt),
        .o_idx  (w_win_idx)
    );

    // Operands pass straight through from the owner; nothing is buffered here.
    always_comb begin
        w_din_a = '0;
        w_din_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant[k]) begin
                w_din_a = req_din_a[k*W +: W];
                w_din_b = req_din_b[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_idx       <= '0;
            r_last      <= IW'(NREQ - 1);
            r_cnt       <= '0;
            r_mac_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            r_mac_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_idx       <= w_win_idx;
                        r_grant     <= w_win_gnt;
                        r_mac_start <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    // Completion is checked first so a done in the timeout cycle still counts.
                    if (mac_done) begin
                        r_rsp_data  <= mac_dout;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_idx;
                        r_grant     <= '0;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_idx;
                        r_grant     <= '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_last  <= r_idx;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign mac_din_a = w_din_a;
    assign mac_din_b = w_din_b;
    assign mac_start = r_mac_start;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mac_sched.sv
// tb/tb_mac_sched.sv - directed vector bench for mac_sched
module tb_mac_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_din_a;
    logic [31:0] req_din_b;
    logic [3:0]  grant;
    logic [7:0]  mac_din_a;
    logic [7:0]  mac_din_b;
    logic        mac_start;
    logic        mac_done;
    logic [15:0] mac_dout;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;

    mac_sched #(.NREQ(4), .PARALLEL(1), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_din_a (req_din_a),
        .req_din_b (req_din_b),
        .grant     (grant),
        .mac_din_a (mac_din_a),
        .mac_din_b (mac_din_b),
        .mac_start (mac_start),
        .mac_done  (mac_done),
        .mac_dout  (mac_dout),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [15:0] dout;
        int          exp_id;
    } rec_t;

    int   n_pass  = 0;
    int   n_total = 0;
    int   n_multi = 0;
    rec_t vec[8];

    always @(negedge clk) begin
        if ($countones(grant) > 1) n_multi++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!mac_start && n < 10);
        chk({name, "_start"}, {31'd0, mac_start}, 32'd1);
    endtask

    task automatic run_txn(input rec_t r, input string name);
        logic [31:0] a;
        logic [31:0] b;
        a = r.a;
        b = r.b;
        req       = r.req;
        req_din_a = r.a;
        req_din_b = r.b;
        wait_start(name);
        chk({name, "_grant"}, {28'd0, grant}, 32'd1 << r.exp_id);
        chk({name, "_din_a"}, {24'd0, mac_din_a}, {24'd0, a[r.exp_id*8 +: 8]});
        chk({name, "_din_b"}, {24'd0, mac_din_b}, {24'd0, b[r.exp_id*8 +: 8]});
        step();
        chk({name, "_start_pulse"}, {31'd0, mac_start}, 32'd0);
        repeat (r.lat) step();
        chk({name, "_grant_busy"}, {28'd0, grant}, 32'd1 << r.exp_id);
        mac_done = 1'b1;
        mac_dout = r.dout;
        step();
        mac_done = 1'b0;
        chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({name, "_id"}, {30'd0, rsp_id}, r.exp_id);
        chk({name, "_data"}, {16'd0, rsp_data}, {16'd0, r.dout});
        chk({name, "_err"}, {31'd0, rsp_err}, 32'd0);
        chk({name, "_grant_off"}, {28'd0, grant}, 32'd0);
        step();
        chk({name, "_valid_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int n;
        logic seen;

        vec[0] = '{4'b0001, 32'h40302003, 32'h41312104, 2, 16'd300,  0};
        vec[1] = '{4'b1111, 32'h40302003, 32'h41312104, 1, 16'h0111, 1};
        vec[2] = '{4'b1111, 32'h40302003, 32'h41312104, 3, 16'h0222, 2};
        vec[3] = '{4'b1111, 32'h40302003, 32'h41312104, 0, 16'h0333, 3};
        vec[4] = '{4'b1111, 32'h40302003, 32'h41312104, 5, 16'h0444, 0};
        vec[5] = '{4'b1010, 32'h8877AA55, 32'h0F1E2D3C, 2, 16'hBEEF, 1};
        vec[6] = '{4'b1010, 32'h8877AA55, 32'h0F1E2D3C, 1, 16'hCAFE, 3};
        vec[7] = '{4'b1001, 32'h8877AA55, 32'h0F1E2D3C, 4, 16'h1357, 0};

        rst = 1'b1; req = '0; req_din_a = '0; req_din_b = '0;
        mac_done = 1'b0; mac_dout = '0;
        step();
        step();
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_start", {31'd0, mac_start}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_din", {24'd0, mac_din_a}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vec[i], $sformatf("vec%0d", i));

        // Timeout: MAC never answers, response lands 64 cycles after BUSY entry.
        req = 4'b0001;
        wait_start("tmo");
        step();
        n = 0;
        while (!rsp_valid && n < 100) begin
            step();
            n++;
        end
        chk("tmo_cycles", n, 64);
        chk("tmo_err", {31'd0, rsp_err}, 32'd1);
        chk("tmo_data", {16'd0, rsp_data}, 32'd0);
        chk("tmo_id", {30'd0, rsp_id}, 32'd0);
        step();

        // Done in the final timeout cycle must win over the abort.
        req = 4'b0010;
        wait_start("edge");
        step();
        repeat (63) step();
        mac_done = 1'b1;
        mac_dout = 16'h1234;
        step();
        mac_done = 1'b0;
        chk("edge_valid", {31'd0, rsp_valid}, 32'd1);
        chk("edge_err", {31'd0, rsp_err}, 32'd0);
        chk("edge_data", {16'd0, rsp_data}, 32'h1234);
        chk("edge_id", {30'd0, rsp_id}, 32'd1);
        step();

        // Reset in BUSY abandons the operation and restores requester 0 priority.
        req = 4'b0100;
        wait_start("rstb");
        chk("rstb_grant", {28'd0, grant}, 32'b0100);
        step();
        step();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        chk("rstb_grant_off", {28'd0, grant}, 32'd0);
        seen = rsp_valid;
        repeat (3) begin
            step();
            seen = seen | rsp_valid;
        end
        chk("rstb_no_rsp", {31'd0, seen}, 32'd0);
        run_txn('{4'b1111, 32'h40302003, 32'h41312104, 1, 16'h0ACE, 0}, "post_rst");

        // Request dropped mid-BUSY still gets its response.
        req = 4'b0100;
        wait_start("drop");
        step();
        req = '0;
        repeat (3) step();
        mac_done = 1'b1;
        mac_dout = 16'h0D0D;
        step();
        mac_done = 1'b0;
        chk("drop_valid", {31'd0, rsp_valid}, 32'd1);
        chk("drop_id", {30'd0, rsp_id}, 32'd2);
        chk("drop_data", {16'd0, rsp_data}, 32'h0D0D);
        step();

        // Stray done while idle is ignored.
        seen = 1'b0;
        mac_done = 1'b1;
        mac_dout = 16'hFFFF;
        repeat (4) begin
            step();
            seen = seen | rsp_valid | mac_start;
        end
        mac_done = 1'b0;
        step();
        seen = seen | rsp_valid | mac_start;
        chk("stray_done", {31'd0, seen}, 32'd0);

        chk("grant_onehot", n_multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
